// File: rtl/flp_mul_pkg.sv
// Shared types and sizing helpers for the sequential {exp, frac} multiplier.
package flp_mul_pkg;

  localparam int FLP_EXP_W  = 9;
  localparam int FLP_FRAC_W = 7;
  localparam int FLP_BIAS   = 255;
  localparam int FLP_PROD_W = 2 * FLP_FRAC_W;
  localparam int FLP_SEXP_W = FLP_EXP_W + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } flp_state_e;

  function automatic int prod_width(input int frac_w);
    return 2 * frac_w;
  endfunction

  function automatic int sexp_width(input int exp_w);
    return exp_w + 2;
  endfunction

  function automatic int max_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/flp_shift_add_mult.sv
// Sequential unsigned shift-add multiplier: bit 0 on the start edge, then one bit per cycle.
module flp_shift_add_mult
  import flp_mul_pkg::*;
#(
  parameter int FRAC_W = FLP_FRAC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [FRAC_W-1:0]           a,
  input  logic [FRAC_W-1:0]           b,
  output logic                        done,
  output logic [prod_width(FRAC_W)-1:0] product
);
  localparam int PROD_W = prod_width(FRAC_W);
  localparam int CNT_W  = $clog2(FRAC_W) + 1;

  logic [PROD_W-1:0] mcand_r;
  logic [PROD_W-1:0] acc_r;
  logic [FRAC_W-1:0] mplier_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic              done_r;

  // Accumulate one partial product per cycle; done pulses with the final sum registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {PROD_W{1'b0}};
      acc_r    <= {PROD_W{1'b0}};
      mplier_r <= {FRAC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= {{FRAC_W{1'b0}}, a} << 1;
      mplier_r <= b >> 1;
      acc_r    <= b[0] ? {{FRAC_W{1'b0}}, a} : {PROD_W{1'b0}};
      cnt_r    <= CNT_W'(1);
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {PROD_W{1'b0}});
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_W'(1);
      if (cnt_r == CNT_W'(FRAC_W - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/flp_mul_seq.sv
// Multi-cycle unsigned {exp, frac} floating-point multiplier with valid/ready handshakes.
// Define FLPMUL_ROUND_EN for round-to-nearest-even; the default build truncates.
module flp_mul_seq
  import flp_mul_pkg::*;
#(
  parameter int EXP_W  = FLP_EXP_W,
  parameter int FRAC_W = FLP_FRAC_W,
  parameter int BIAS   = FLP_BIAS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W-1:0] a,
  input  logic [EXP_W+FRAC_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W-1:0] result,
  output logic                    ovf,
  output logic                    unf
);
  localparam int OP_W   = EXP_W + FRAC_W;
  localparam int PROD_W = prod_width(FRAC_W);
  localparam int SEXP_W = sexp_width(EXP_W);
  localparam logic signed [SEXP_W-1:0] E_MAX_S = SEXP_W'(max_exp(EXP_W));
  localparam logic signed [SEXP_W-1:0] BIAS_S  = SEXP_W'(BIAS);

  flp_state_e               state_r, state_nxt_s;
  logic [PROD_W-1:0]        p_r, p_nxt_s;
  logic signed [SEXP_W-1:0] e_r, e_nxt_s, e_start_s, fin_e_s;
  logic [FRAC_W-1:0]        fin_f_s;
  logic [OP_W-1:0]          result_r, result_nxt_s, fin_result_s;
  logic                     ovf_r, ovf_nxt_s, fin_ovf_s;
  logic                     unf_r, unf_nxt_s, fin_unf_s;
  logic                     out_valid_r, in_ready_r;
  logic                     accept_s, mul_done_s;
  logic [PROD_W-1:0]        mul_prod_s;

  assign accept_s  = in_valid && (state_r == IDLE);
  assign e_start_s = $signed({2'b00, a[OP_W-1:FRAC_W]}) + $signed({2'b00, b[OP_W-1:FRAC_W]}) - BIAS_S;

  flp_shift_add_mult #(.FRAC_W(FRAC_W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_s),
    .a       (a[FRAC_W-1:0]),
    .b       (b[FRAC_W-1:0]),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

`ifdef FLPMUL_ROUND_EN
  logic              round_up_s;
  logic [FRAC_W:0]   frac_inc_s;

  // Round-to-nearest-even on the discarded half; a carry-out renormalises to 100..0.
  always_comb begin
    round_up_s = p_r[FRAC_W-1] && ((|p_r[FRAC_W-2:0]) || p_r[FRAC_W]);
    frac_inc_s = {1'b0, p_r[PROD_W-1:FRAC_W]} + {{FRAC_W{1'b0}}, round_up_s};
    if (frac_inc_s[FRAC_W]) begin
      fin_f_s = {1'b1, {(FRAC_W-1){1'b0}}};
      fin_e_s = e_r + SEXP_W'(1);
    end else begin
      fin_f_s = frac_inc_s[FRAC_W-1:0];
      fin_e_s = e_r;
    end
  end
`else
  // Truncation keeps the upper half of the normalised product.
  always_comb begin
    fin_f_s = p_r[PROD_W-1:FRAC_W];
    fin_e_s = e_r;
  end
`endif

  // Final exponent range check: flush to zero below 0, saturate above the field maximum.
  always_comb begin
    fin_result_s = {fin_e_s[EXP_W-1:0], fin_f_s};
    fin_ovf_s    = 1'b0;
    fin_unf_s    = 1'b0;
    if (fin_e_s[SEXP_W-1]) begin
      fin_result_s = {OP_W{1'b0}};
      fin_unf_s    = 1'b1;
    end else if (fin_e_s > E_MAX_S) begin
      fin_result_s = {OP_W{1'b1}};
      fin_ovf_s    = 1'b1;
    end else begin
      fin_ovf_s    = 1'b0;
    end
  end

  // Next-state and datapath update for the control FSM.
  always_comb begin
    state_nxt_s  = state_r;
    p_nxt_s      = p_r;
    e_nxt_s      = e_r;
    result_nxt_s = result_r;
    ovf_nxt_s    = ovf_r;
    unf_nxt_s    = unf_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = MUL;
          e_nxt_s     = e_start_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          p_nxt_s = mul_prod_s;
          if (mul_prod_s == {PROD_W{1'b0}}) begin
            state_nxt_s  = DONE;
            result_nxt_s = {OP_W{1'b0}};
            ovf_nxt_s    = 1'b0;
            unf_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = NORM;
          end
        end else begin
          state_nxt_s = MUL;
        end
      end
      NORM: begin
        if (p_r[PROD_W-1]) begin
`ifdef FLPMUL_ROUND_EN
          state_nxt_s  = ROUND;
`else
          state_nxt_s  = DONE;
          result_nxt_s = fin_result_s;
          ovf_nxt_s    = fin_ovf_s;
          unf_nxt_s    = fin_unf_s;
`endif
        end else begin
          p_nxt_s = p_r << 1;
          e_nxt_s = e_r - SEXP_W'(1);
        end
      end
      ROUND: begin
`ifdef FLPMUL_ROUND_EN
        state_nxt_s  = DONE;
        result_nxt_s = fin_result_s;
        ovf_nxt_s    = fin_ovf_s;
        unf_nxt_s    = fin_unf_s;
`else
        state_nxt_s  = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      p_r         <= {PROD_W{1'b0}};
      e_r         <= {SEXP_W{1'b0}};
      result_r    <= {OP_W{1'b0}};
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      p_r         <= p_nxt_s;
      e_r         <= e_nxt_s;
      result_r    <= result_nxt_s;
      ovf_r       <= ovf_nxt_s;
      unf_r       <= unf_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
      in_ready_r  <= (state_nxt_s == IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule

// File: tb/tb_flp_mul_seq.sv
// Self-checking bench for flp_mul_seq: directed vector table, handshake corner cases, random vs. model.
module tb_flp_mul_seq;
  localparam int EXP_W  = 9;
  localparam int FRAC_W = 7;
  localparam int BIAS   = 255;
`ifdef FLPMUL_ROUND_EN
  localparam int RL = 1;
  localparam logic [15:0] RES_B = 16'h7FC9;
`else
  localparam int RL = 0;
  localparam logic [15:0] RES_B = 16'h7FC8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_ready, out_valid, ovf, unf;
  logic [15:0] result;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  flp_mul_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .BIAS(BIAS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference computed from the number format directly: integer product, count shifts, range check.
  task automatic model(input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] res, output logic ov, output logic un, output int lat);
    int fa, fb, ea, eb, p, s, e, fr;
    fa = int'(av[6:0]);
    fb = int'(bv[6:0]);
    ea = int'(av[15:7]);
    eb = int'(bv[15:7]);
    p  = fa * fb;
    ov = 1'b0;
    un = 1'b0;
    if (p == 0) begin
      res = 16'h0000;
      lat = FRAC_W;
    end else begin
      s = 0;
      while (p < (1 << (2 * FRAC_W - 1))) begin
        p = p * 2;
        s++;
      end
      e   = ea + eb - BIAS - s;
      fr  = p / (1 << FRAC_W);
      lat = FRAC_W + s + 1;
`ifdef FLPMUL_ROUND_EN
      begin
        int rem;
        rem = p % (1 << FRAC_W);
        lat++;
        if (rem > (1 << (FRAC_W - 1)) || (rem == (1 << (FRAC_W - 1)) && (fr % 2) == 1)) fr++;
        if (fr == (1 << FRAC_W)) begin
          fr = 1 << (FRAC_W - 1);
          e++;
        end
      end
`endif
      if (e < 0) begin
        res = 16'h0000;
        un  = 1'b1;
      end else if (e > (1 << EXP_W) - 1) begin
        res = 16'hFFFF;
        ov  = 1'b1;
      end else begin
        res = 16'(e * (1 << FRAC_W) + fr);
      end
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_out_valid", 32'(out_valid), 32'd0);
    chk("consume_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] eres,
                       input logic eovf, input logic eunf, input int elat, input int hold);
    int lat;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(elat));
    chk("result", 32'(result), 32'(eres));
    chk("ovf", 32'(ovf), 32'(eovf));
    chk("unf", 32'(unf), 32'(eunf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", 32'(result), 32'(eres));
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    consume();
  endtask

  initial begin
    logic [15:0] av, bv, eres;
    logic        eov, eun;
    int          elat, lat;

    vecs[0] = '{16'h7FC0, 16'h7FC0, 16'h7F40, 1'b0, 1'b0, 9 + RL};
    vecs[1] = '{16'h7FE0, 16'h7FE1, RES_B,    1'b0, 1'b0, 8 + RL};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 8 + RL};
    vecs[3] = '{16'h0040, 16'h0040, 16'h0000, 1'b0, 1'b1, 9 + RL};
    vecs[4] = '{16'h7F80, 16'h7FC0, 16'h0000, 1'b0, 1'b0, 7};
    vecs[5] = '{16'h7F81, 16'h7F81, 16'h7940, 1'b0, 1'b0, 21 + RL};
    vecs[6] = '{16'hFFFF, 16'h7FFF, 16'hFFFE, 1'b0, 1'b0, 8 + RL};
    vecs[7] = '{16'h007F, 16'h7FFF, 16'h007E, 1'b0, 1'b0, 8 + RL};
    vecs[8] = '{16'h007F, 16'h7F7F, 16'h0000, 1'b0, 1'b1, 8 + RL};
    vecs[9] = '{16'hFFFF, 16'h807F, 16'hFFFF, 1'b1, 1'b0, 8 + RL};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_unf", 32'(unf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].unf, vecs[i].lat, i % 3);

    // Back-pressure: result held, second operand waits for the output handshake.
    @(negedge clk);
    a = 16'h7FC0;
    b = 16'h7FC0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h7FE0;
    b = 16'h7FE1;
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'(9 + RL));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result", 32'(result), 32'h7F40);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    consume();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second_accept", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("bp2_latency", 32'(lat), 32'(8 + RL));
    chk("bp2_result", 32'(result), 32'(RES_B));
    consume();

    // Reset while normalising: nothing emitted, block idle at once, next op clean.
    @(negedge clk);
    a = 16'h7F81;
    b = 16'h7F81;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h7F81, 16'h7F81, 16'h7940, 1'b0, 1'b0, 21 + RL, 0);

    for (int n = 0; n < 150; n++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        av[15:7] = 9'($urandom_range(180, 330));
        bv[15:7] = 9'($urandom_range(180, 330));
      end
      if ($urandom_range(0, 3) == 0) av[6:0] = 7'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bv[6:0] = 7'h7F;
      model(av, bv, eres, eov, eun, elat);
      do_op(av, bv, eres, eov, eun, elat, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
